image_sharpen: RTL

Streaming 3x3 Laplacian sharpening filter for the image-enhancement pipeline. It accepts an 8-bit grayscale frame in raster order, one pixel per enabled clock. It emits the sharpened frame in the same raster order, also one pixel per enable, and clamps results to 0..255. It sits directly upstream of the image-addition stage: `sharpened_img` and `en_out` drive that stage's first image input.

---
 rtl/image_sharpen_if.sv | 29 ++
 rtl/image_sharpen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/image_sharpen_if.sv
// -----------------------------------------------------------------------------
// image_sharpen_if
// Pixel stream bundle for the image_sharpen filter.
//   input_img     : 8-bit unsigned input pixel, raster order
//   en_in         : input_img valid this cycle (no backpressure)
//   sharpened_img : 8-bit unsigned sharpened pixel
//   en_out        : sharpened_img valid this cycle
//   frame_done    : one-cycle pulse after the last output pixel of a frame
//   ovf           : sticky flag, input arrived while the frame was flushing
// Modports: master = pixel source / result sink, slave = filter.
// -----------------------------------------------------------------------------
interface image_sharpen_if;
  logic [7:0] input_img;
  logic       en_in;
  logic [7:0] sharpened_img;
  logic       en_out;
  logic       frame_done;
  logic       ovf;

  modport master (
    output input_img, en_in,
    input  sharpened_img, en_out, frame_done, ovf
  );

  modport slave (
    input  input_img, en_in,
    output sharpened_img, en_out, frame_done, ovf
  );
endinterface

// File: rtl/image_sharpen.sv
// -----------------------------------------------------------------------------
// image_sharpen
// Streaming 3x3 Laplacian sharpening filter. Takes an 8-bit grayscale frame in
// raster order (one pixel per en_in) and emits the sharpened frame in raster
// order, clamped to 0..255. Border pixels pass through unchanged.
//
// Ports:
//   clk : clock, all logic on posedge
//   rst : synchronous active-high reset
//   bus : image_sharpen_if.slave (input_img, en_in, sharpened_img, en_out,
//         frame_done, ovf)
// Parameters:
//   WIDTH  : pixels per row (>= 3)
//   HEIGHT : rows per frame (>= 3)
// Configuration macro:
//   IMAGE_SHARPEN_DIAG_EN : when defined, the kernel is 9*c - sum(8 neighbours)
//                           instead of 5*c - (up+down+left+right).
// -----------------------------------------------------------------------------
module image_sharpen #(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 128
) (
  input logic           clk,
  input logic           rst,
  image_sharpen_if.slave bus
);

  // Window store: the incoming pixel is the newest window sample, the buffer
  // keeps the previous 2*WIDTH+1. The diagonal kernel also needs the up-left
  // neighbour, which sits one slot further back, so that build keeps one more.
`ifdef IMAGE_SHARPEN_DIAG_EN
  localparam int DEPTH = 2*WIDTH + 2;
`else
  localparam int DEPTH = 2*WIDTH + 1;
`endif
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q;
  logic [CW-1:0] in_col_q, out_col_q;
  logic [RW-1:0] in_row_q, out_row_q;
  logic [7:0]    sharp_q;
  logic          en_out_q, flush_last_q, frame_done_q, ovf_q;

  logic accept, emit, step, ovf_set;
  logic in_last, out_last, fill_done, border;

  // Slot holding the sample k positions older than the incoming pixel.
  function automatic logic [AW-1:0] tap(input logic [AW-1:0] wp, input int k);
    int t;
    t = int'(wp) - k;
    if (t < 0) t = t + DEPTH;
    return AW'(t);
  endfunction

  function automatic logic signed [12:0] ext(input logic [7:0] v);
    return $signed({5'b0, v});
  endfunction

  function automatic logic [7:0] sat_u8(input logic signed [12:0] v);
    if (v < 13'sd0)        return 8'd0;
    else if (v > 13'sd255) return 8'd255;
    else                   return v[7:0];
  endfunction

  assign in_last   = (in_row_q == ROW_LAST) && (in_col_q == COL_LAST);
  assign out_last  = (out_row_q == ROW_LAST) && (out_col_q == COL_LAST);
  assign fill_done = (in_row_q == RW'(1)) && (in_col_q == '0);
  assign border    = (out_row_q == '0) || (out_row_q == ROW_LAST) ||
                     (out_col_q == '0) || (out_col_q == COL_LAST);

  // Window taps relative to the incoming pixel at linear index q; the centre
  // is output index q-WIDTH-1.
  logic [7:0] px_c, px_u, px_d, px_l, px_r;
  assign px_c = mem_q[tap(wp_q, WIDTH + 1)];
  assign px_u = mem_q[tap(wp_q, 2*WIDTH + 1)];
  assign px_d = mem_q[tap(wp_q, 1)];
  assign px_l = mem_q[tap(wp_q, WIDTH + 2)];
  assign px_r = mem_q[tap(wp_q, WIDTH)];

  logic signed [12:0] acc;
`ifdef IMAGE_SHARPEN_DIAG_EN
  logic [7:0] px_ul, px_ur, px_dl, px_dr;
  assign px_ul = mem_q[tap(wp_q, 2*WIDTH + 2)];
  assign px_ur = mem_q[tap(wp_q, 2*WIDTH)];
  assign px_dl = mem_q[tap(wp_q, 2)];
  assign px_dr = bus.input_img;

  always_comb begin
    acc = 13'sd9 * ext(px_c) - ext(px_u) - ext(px_d) - ext(px_l) - ext(px_r)
        - ext(px_ul) - ext(px_ur) - ext(px_dl) - ext(px_dr);
  end
`else
  always_comb begin
    acc = 13'sd5 * ext(px_c) - ext(px_u) - ext(px_d) - ext(px_l) - ext(px_r);
  end
`endif

  logic [7:0] pix_d;
  assign pix_d = border ? px_c : sat_u8(acc);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.en_in) state_d = FILL;
      FILL:    if (bus.en_in && fill_done) state_d = RUN;
      RUN:     if (bus.en_in && in_last) state_d = FLUSH;
      FLUSH:   if (out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control outputs: FLUSH keeps advancing the window with dummy writes so the
  // centre tap stays at the same offset while the last row drains.
  always_comb begin
    accept  = 1'b0;
    emit    = 1'b0;
    ovf_set = 1'b0;
    unique case (state_q)
      IDLE, FILL: accept = bus.en_in;
      RUN: begin
        accept = bus.en_in;
        emit   = bus.en_in;
      end
      FLUSH: begin
        emit    = 1'b1;
        ovf_set = bus.en_in;
      end
      default: ;
    endcase
    step = accept || (state_q == FLUSH);
  end

  // Window store (data, not reset)
  always_ff @(posedge clk) begin
    if (step) mem_q[wp_q] <= bus.input_img;
  end

  // Stage p0 -> outputs: counters, registered pixel, frame flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q         <= '0;
      in_col_q     <= '0;
      in_row_q     <= '0;
      out_col_q    <= '0;
      out_row_q    <= '0;
      sharp_q      <= '0;
      en_out_q     <= 1'b0;
      flush_last_q <= 1'b0;
      frame_done_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      if (step) wp_q <= (wp_q == AW'(DEPTH - 1)) ? '0 : wp_q + AW'(1);

      if (accept) begin
        if (in_last) begin
          in_col_q <= '0;
          in_row_q <= '0;
        end else if (in_col_q == COL_LAST) begin
          in_col_q <= '0;
          in_row_q <= in_row_q + RW'(1);
        end else begin
          in_col_q <= in_col_q + CW'(1);
        end
      end

      if (emit) begin
        sharp_q <= pix_d;
        if (out_last) begin
          out_col_q <= '0;
          out_row_q <= '0;
        end else if (out_col_q == COL_LAST) begin
          out_col_q <= '0;
          out_row_q <= out_row_q + RW'(1);
        end else begin
          out_col_q <= out_col_q + CW'(1);
        end
      end

      en_out_q     <= emit;
      // Two-step delay keeps frame_done off the cycle of the last en_out.
      flush_last_q <= (state_q == FLUSH) && out_last;
      frame_done_q <= flush_last_q;
      if (ovf_set) ovf_q <= 1'b1;
    end
  end

  assign bus.sharpened_img = sharp_q;
  assign bus.en_out        = en_out_q;
  assign bus.frame_done    = frame_done_q;
  assign bus.ovf           = ovf_q;

endmodule
